yuu_common_mem_arbiter: RTL and testbench

YUU_COMMON_MEM_ARBITER -- requirements
Module: yuu_common_mem_arbiter

---
 rtl/yuu_common_pkg.sv | 8 +
 rtl/yuu_common_rr_picker.sv | 20 ++
 rtl/yuu_common_mem_arbiter.sv | 97 +++++++++
 tb/tb_yuu_common_mem_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/yuu_common_pkg.sv
// yuu_common_pkg: shared state enum and default parameters for the memory arbiter.
package yuu_common_pkg;
  typedef enum logic {ARB, LOCKED} yuu_mem_arb_state_e;
  localparam int NUM_REQ_DEF    = 4;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int MAX_LOCK_DEF   = 8;
endpackage

// File: rtl/yuu_common_rr_picker.sv
// yuu_common_rr_picker: combinational round-robin pick, first request at or above ptr with wrap.
module yuu_common_rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic [2*N-1:0] rot, wide;
  logic [N-1:0] first;
  // rotate so ptr sits at bit 0, take the lowest set bit, rotate back
  always_comb begin
    rot = {req, req} >> ptr;
    first = '0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) first = N'(1) << k;
    wide = {first, first} << ptr;
    grant = wide[2*N-1:N];
  end
endmodule

// File: rtl/yuu_common_mem_arbiter.sv
// yuu_common_mem_arbiter: round-robin arbiter with locked bursts in front of a single-port SRAM.
// One beat per cycle; every beat gets a one-cycle completion pulse one cycle later.
module yuu_common_mem_arbiter
  import yuu_common_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_LOCK   = MAX_LOCK_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ-1:0]              req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            mem_cs,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  output logic [DATA_WIDTH/8-1:0]         mem_be,
  input  logic [DATA_WIDTH-1:0]           mem_rdata
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = DATA_WIDTH / 8;
  yuu_mem_arb_state_e state, state_n;
  logic [PW-1:0] rr_ptr, ptr_n, owner, owner_n, win;
  logic [7:0] lock_cnt, cnt_n;
  logic [NUM_REQ-1:0] arb_grant, grant, rsp_q;
  logic rd_q, xfer;
  function automatic logic [PW-1:0] nxt(logic [PW-1:0] x);
    return (int'(x) == NUM_REQ - 1) ? '0 : x + PW'(1);
  endfunction
  yuu_common_rr_picker #(.N(NUM_REQ), .PW(PW)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant)
  );
  // ready is suppressed during reset so nothing issued then can transfer
  assign grant = rst ? '0 :
                 (state == ARB) ? arb_grant :
                 (req_valid[owner] ? NUM_REQ'(1) << owner : '0);
  assign xfer = |grant;
  assign req_ready = grant;
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) if (grant[i]) win = PW'(i);
  end
  assign mem_cs    = xfer;
  assign mem_we    = xfer & req_write[win];
  assign mem_addr  = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_wdata = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
  assign mem_be    = req_wstrb[win*SW +: SW];
  always_comb begin
    state_n = state;
    ptr_n   = rr_ptr;
    owner_n = owner;
    cnt_n   = lock_cnt;
    if (xfer && state == ARB) begin
      ptr_n = nxt(win);
      if (req_lock[win]) begin
        state_n = LOCKED;
        owner_n = win;
        cnt_n   = 8'd1;
      end
    end else if (xfer) begin
      if (!req_lock[win] || lock_cnt == 8'(MAX_LOCK)) begin
        state_n = ARB;
        ptr_n   = nxt(owner);
      end else cnt_n = lock_cnt + 8'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB;
      rr_ptr   <= '0;
      owner    <= '0;
      lock_cnt <= '0;
      rsp_q    <= '0;
      rd_q     <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= ptr_n;
      owner    <= owner_n;
      lock_cnt <= cnt_n;
      rsp_q    <= grant;
      rd_q     <= xfer & ~req_write[win];
    end
  end
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rd_q ? mem_rdata : '0;
endmodule

// File: tb/tb_yuu_common_mem_arbiter.sv
// tb_yuu_common_mem_arbiter: directed and random checks of two arbiters (MAX_LOCK 8 and 2)
// driven by the same requests, each compared with its own behavioural model.
module tb_yuu_common_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] v = '0, w = '0, l = '0;
  logic [63:0] addr = '0;
  logic [127:0] wdata = '0;
  logic [15:0] wstrb = '0;
  logic [31:0] mem_rdata = '0;
  logic [3:0] ready [2];
  logic [3:0] rspv [2];
  logic [31:0] rdata [2];
  logic cs [2];
  logic we [2];
  logic [15:0] maddr [2];
  logic [31:0] mwd [2];
  logic [3:0] mbe [2];
  int checks = 0, errors = 0;
  int ptr [2], owner [2], cnt [2], g [2];
  bit locked [2];
  int ml [2] = '{8, 2};
  logic [3:0] exp_rsp [2];
  bit exp_rd [2];
  int hits [4];
  always #5 clk = ~clk;
  yuu_common_mem_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(v), .req_ready(ready[0]), .req_write(w), .req_lock(l),
    .req_addr(addr), .req_wdata(wdata), .req_wstrb(wstrb), .rsp_valid(rspv[0]), .rsp_rdata(rdata[0]),
    .mem_cs(cs[0]), .mem_we(we[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_be(mbe[0]),
    .mem_rdata(mem_rdata)
  );
  yuu_common_mem_arbiter #(.MAX_LOCK(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v), .req_ready(ready[1]), .req_write(w), .req_lock(l),
    .req_addr(addr), .req_wdata(wdata), .req_wstrb(wstrb), .rsp_valid(rspv[1]), .rsp_rdata(rdata[1]),
    .mem_cs(cs[1]), .mem_we(we[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_be(mbe[1]),
    .mem_rdata(mem_rdata)
  );
  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic int pick(int d);
    if (locked[d]) return v[owner[d]] ? owner[d] : -1;
    for (int k = 0; k < 4; k++) if (v[(ptr[d] + k) % 4]) return (ptr[d] + k) % 4;
    return -1;
  endfunction
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ptr[d] = 0; owner[d] = 0; cnt[d] = 0; locked[d] = 0; exp_rsp[d] = '0; exp_rd[d] = 0;
    end
  endtask
  task automatic update(int d);
    int i;
    i = g[d];
    exp_rsp[d] = '0;
    exp_rd[d] = 0;
    if (i >= 0) begin
      if (!locked[d]) begin
        ptr[d] = (i + 1) % 4;
        if (l[i]) begin locked[d] = 1; owner[d] = i; cnt[d] = 1; end
      end else if (!l[i] || cnt[d] == ml[d]) begin
        locked[d] = 0;
        ptr[d] = (owner[d] + 1) % 4;
      end else cnt[d]++;
      exp_rsp[d] = 4'(1 << i);
      exp_rd[d] = !w[i];
    end
  endtask
  // called just after a negedge with inputs already applied; returns just after the next negedge
  task automatic step();
    #1;
    for (int d = 0; d < 2; d++) begin
      g[d] = pick(d);
      chk($sformatf("d%0d ready", d), ready[d], g[d] < 0 ? 4'b0 : 4'(1 << g[d]));
      chk($sformatf("d%0d mem_cs", d), cs[d], g[d] >= 0);
      if (g[d] >= 0) begin
        chk($sformatf("d%0d mem_we", d), we[d], w[g[d]]);
        chk($sformatf("d%0d mem_addr", d), maddr[d], addr[g[d]*16 +: 16]);
        chk($sformatf("d%0d mem_wdata", d), mwd[d], wdata[g[d]*32 +: 32]);
        chk($sformatf("d%0d mem_be", d), mbe[d], wstrb[g[d]*4 +: 4]);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) update(d);
    mem_rdata = $urandom;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rsp_valid", d), rspv[d], exp_rsp[d]);
      chk($sformatf("d%0d rsp_rdata", d), rdata[d], (exp_rsp[d] != 0 && exp_rd[d]) ? mem_rdata : 32'h0);
    end
    @(negedge clk);
  endtask
  task automatic reset_checks(string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d ready", tag, d), ready[d], 4'b0);
      chk($sformatf("%s d%0d rsp_valid", tag, d), rspv[d], 4'b0);
      chk($sformatf("%s d%0d mem_cs", tag, d), cs[d], 1'b0);
      chk($sformatf("%s d%0d mem_we", tag, d), we[d], 1'b0);
      chk($sformatf("%s d%0d rsp_rdata", tag, d), rdata[d], 32'h0);
    end
  endtask
  task automatic do_reset();
    v = 4'b1111; w = 4'b0000; l = 4'b0000;
    rst = 1'b1;
    #1 reset_checks("rst");
    @(posedge clk);
    #1 reset_checks("rst_edge");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    v = '0;
  endtask
  task automatic rand_inputs();
    v = 4'($urandom); w = 4'($urandom); l = 4'($urandom & $urandom);
    addr = {$urandom, $urandom};
    wdata = {$urandom, $urandom, $urandom, $urandom};
    wstrb = 16'($urandom);
  endtask
  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    // two readers at ptr 0: req 0 then req 2
    rand_inputs(); v = 4'b0101; w = 4'b0000; l = 4'b0000;
    step();
    chk("rr first", g[0], 0);
    v = 4'b0100;
    step();
    chk("rr second", g[0], 2);
    chk("rr second rsp", rspv[0], 4'b0100);
    // write from req 3
    v = 4'b1000; w = 4'b1000; l = 4'b0000;
    addr[48 +: 16] = 16'h0010; wdata[96 +: 32] = 32'hA5A5A5A5; wstrb[12 +: 4] = 4'hF;
    #1;
    chk("wr mem_cs", cs[0], 1'b1);
    chk("wr mem_we", we[0], 1'b1);
    chk("wr mem_addr", maddr[0], 16'h0010);
    step();
    chk("wr rsp", rspv[0], 4'b1000);
    chk("wr rdata", rdata[0], 32'h0);
    // req 1 locked for 3 beats, req 0 waiting throughout
    do_reset();
    w = 4'b0000;
    v = 4'b0010; l = 4'b0010;
    step();
    v = 4'b0011;
    step(); chk("lock stall b2", ready[0] === 4'b0010 || g[0] == 1, 1'b1);
    step(); chk("lock stall b3", g[0], 1);
    l = 4'b0000;
    step(); chk("lock release", g[0], 1);
    v = 4'b0001;
    step(); chk("after release", g[0], 0);
    // MAX_LOCK=2 instance: req 2 keeps lock asserted while req 3 waits
    do_reset();
    v = 4'b1100; l = 4'b0100; w = 4'b0000;
    for (int k = 0; k < 4; k++) step();
    chk("maxlock forced handoff", g[1], 3);
    // reset asserted right after a read transfer
    do_reset();
    v = 4'b0001; w = 4'b0000; l = 4'b0000;
    #1 chk("pre-rst ready", ready[0], 4'b0001);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 reset_checks("mid_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post-rst grant", g[0], 0);
    // all four requesting continuously
    do_reset();
    v = 4'b1111; w = 4'b0000; l = 4'b0000;
    for (int i = 0; i < 4; i++) hits[i] = 0;
    for (int k = 0; k < 16; k++) begin
      rand_inputs(); v = 4'b1111; l = 4'b0000;
      step();
      chk("rr order", g[0], k % 4);
      if (g[0] >= 0) hits[g[0]]++;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("rr hits%0d", i), hits[i], 4);
    // random traffic
    for (int k = 0; k < 400; k++) begin
      rand_inputs();
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
